dadd_seq: RTL

DADD_SEQ -- requirements
Module: dadd_seq

---
 rtl/dadd_pkg.sv | 66 ++++++
 rtl/dadd_nextop.sv | 21 ++
 rtl/dadd_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dadd_pkg.sv
// Shared types and constants for the pixel-adder sequencer.
// Define DADD_SHADE_EN to include the SHADE op.
package dadd_pkg;

`ifdef DADD_SHADE_EN
  typedef enum logic [2:0] {
    OpIdle, OpSrcz1, OpSrcz2, OpGourd, OpGourz, OpShade, OpPat
  } op_e;
  localparam int unsigned NumOps = 7;
`else
  typedef enum logic [2:0] {
    OpIdle, OpSrcz1, OpSrcz2, OpGourd, OpGourz, OpPat
  } op_e;
  localparam int unsigned NumOps = 6;
`endif

  localparam int unsigned CmdGourd    = 0;
  localparam int unsigned CmdGourz    = 1;
  localparam int unsigned CmdSrcshade = 2;
  localparam int unsigned CmdZadd     = 3;
  localparam int unsigned CmdPatdadd  = 4;
  localparam int unsigned CmdW        = 5;

  typedef struct packed {
    logic [2:0] asel;
    logic [2:0] bsel;
    logic [2:0] mode;
    logic [1:0] dsel;
  } op_code_t;

  localparam op_code_t CodeIdle  = '{asel: 3'd0, bsel: 3'd0, mode: 3'd0, dsel: 2'd0};
  localparam op_code_t CodeSrcz1 = '{asel: 3'd0, bsel: 3'd4, mode: 3'd0, dsel: 2'd2};
  localparam op_code_t CodeSrcz2 = '{asel: 3'd1, bsel: 3'd5, mode: 3'd0, dsel: 2'd2};
  localparam op_code_t CodeGourd = '{asel: 3'd2, bsel: 3'd6, mode: 3'd1, dsel: 2'd0};
  localparam op_code_t CodeGourz = '{asel: 3'd3, bsel: 3'd7, mode: 3'd1, dsel: 2'd1};
  localparam op_code_t CodeShade = '{asel: 3'd2, bsel: 3'd6, mode: 3'd4, dsel: 2'd0};
  localparam op_code_t CodePat   = '{asel: 3'd0, bsel: 3'd0, mode: 3'd7, dsel: 2'd3};

  function automatic op_code_t op_code(op_e op);
    op_code_t code;
    code = CodeIdle;
    case (op)
      OpSrcz1: code = CodeSrcz1;
      OpSrcz2: code = CodeSrcz2;
      OpGourd: code = CodeGourd;
      OpGourz: code = CodeGourz;
`ifdef DADD_SHADE_EN
      OpShade: code = CodeShade;
`endif
      OpPat:   code = CodePat;
      default: code = CodeIdle;
    endcase
    return code;
  endfunction

  // Ops that sweep every lane before moving on.
  function automatic logic op_iterates(op_e op);
    logic it;
    it = (op == OpGourd) || (op == OpGourz);
`ifdef DADD_SHADE_EN
    it = it || (op == OpShade);
`endif
    return it;
  endfunction

endpackage

// File: rtl/dadd_nextop.sv
// Priority selector: first enabled op strictly after the current one, else OpIdle.
// en[k] enables the op whose encoding is k+1.
module dadd_nextop
  import dadd_pkg::*;
(
  input  op_e               cur,
  input  logic [NumOps-2:0] en,
  output op_e               nxt
);

  always_comb begin
    nxt = OpIdle;
    // Descending scan so the lowest qualifying op wins.
    for (int i = NumOps - 1; i >= 1; i--) begin
      if ((i > int'(cur)) && en[i-1]) begin
        nxt = op_e'(i[2:0]);
      end
    end
  end

endmodule

// File: rtl/dadd_seq.sv
// Pixel-adder op sequencer: steps through enabled ops and lanes on each adv tick.
// Define DADD_SHADE_EN to include the SHADE op.
module dadd_seq
  import dadd_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned LW    = 2
) (
  input  logic          clk,
  input  logic          resetl,
  input  logic          cmd_ld,
  input  logic [31:0]   cmd_din,
  input  logic          start,
  input  logic          adv,
  output logic          busy,
  output logic          done,
  output logic          start_drop,
  output logic          op_valid,
  output logic [2:0]    daddasel,
  output logic [2:0]    daddbsel,
  output logic [2:0]    daddmode,
  output logic [1:0]    data_sel,
  output logic [LW-1:0] lane
);

  logic [CmdW-1:0]   shadow_q, shadow_d;
  logic [CmdW-1:0]   cmd_q, cmd_d;
  op_e               state_q, state_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;
  logic [NumOps-2:0] start_en, run_en;
  op_e               start_nxt, run_nxt;
  op_code_t          code;

`ifdef DADD_SHADE_EN
  assign start_en = {shadow_q[CmdPatdadd], shadow_q[CmdSrcshade], shadow_q[CmdGourz],
                     shadow_q[CmdGourd], shadow_q[CmdZadd], shadow_q[CmdZadd]};
  assign run_en   = {cmd_q[CmdPatdadd], cmd_q[CmdSrcshade], cmd_q[CmdGourz],
                     cmd_q[CmdGourd], cmd_q[CmdZadd], cmd_q[CmdZadd]};
  logic unused_cmd;
  assign unused_cmd = ^cmd_din[31:CmdW];
`else
  assign start_en = {shadow_q[CmdPatdadd], shadow_q[CmdGourz],
                     shadow_q[CmdGourd], shadow_q[CmdZadd], shadow_q[CmdZadd]};
  assign run_en   = {cmd_q[CmdPatdadd], cmd_q[CmdGourz],
                     cmd_q[CmdGourd], cmd_q[CmdZadd], cmd_q[CmdZadd]};
  logic unused_cmd;
  assign unused_cmd = ^{cmd_din[31:CmdW], shadow_q[CmdSrcshade], cmd_q[CmdSrcshade]};
`endif

  dadd_nextop u_start_sel (
    .cur (OpIdle),
    .en  (start_en),
    .nxt (start_nxt)
  );

  dadd_nextop u_run_sel (
    .cur (state_q),
    .en  (run_en),
    .nxt (run_nxt)
  );

  always_comb begin
    shadow_d = cmd_ld ? cmd_din[CmdW-1:0] : shadow_q;
    cmd_d    = cmd_q;
    state_d  = state_q;
    lane_d   = lane_q;
    done_d   = 1'b0;
    drop_d   = 1'b0;
    if (state_q == OpIdle) begin
      if (start) begin
        // Shadow is sampled before this cycle's cmd_ld takes effect.
        cmd_d   = shadow_q;
        state_d = start_nxt;
        lane_d  = '0;
        done_d  = (start_nxt == OpIdle);
      end
    end else begin
      drop_d = start;
      if (adv) begin
        if (op_iterates(state_q) && (lane_q != LW'(LANES - 1))) begin
          lane_d = lane_q + 1'b1;
        end else begin
          lane_d  = '0;
          state_d = run_nxt;
          done_d  = (run_nxt == OpIdle);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      shadow_q <= '0;
      cmd_q    <= '0;
      state_q  <= OpIdle;
      lane_q   <= '0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cmd_q    <= cmd_d;
      state_q  <= state_d;
      lane_q   <= lane_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  assign code       = op_code(state_q);
  assign busy       = (state_q != OpIdle);
  assign op_valid   = busy;
  assign done       = done_q;
  assign start_drop = drop_q;
  assign daddasel   = code.asel;
  assign daddbsel   = code.bsel;
  assign daddmode   = code.mode;
  assign data_sel   = code.dsel;
  assign lane       = lane_q;

endmodule
